// File: rtl/edfic_pkg.sv
// Shared types and helpers for the pipelined EDFIC deadline arbiter.
// Node fields are sized for the widest supported configuration (PrioWidth <= 32, IdxWidth <= 16).
package edfic_pkg;

   localparam int PRIO_MAX_W = 32;
   localparam int IDX_MAX_W  = 16;

   typedef struct packed {
      logic [PRIO_MAX_W-1:0] prio;
      logic [IDX_MAX_W-1:0]  idx;
      logic                  valid;
   } node_t;

   typedef enum logic {
      SEL_A = 1'b0,
      SEL_B = 1'b1
   } sel_e;

   // Widens a width-bit priority to PRIO_MAX_W so one full-width compare serves every PrioWidth.
   function automatic logic [PRIO_MAX_W-1:0] prio_extend(
      input logic [PRIO_MAX_W-1:0] raw,
      input int unsigned           width,
      input logic                  is_signed
   );
      logic signed [PRIO_MAX_W-1:0] w_tmp;
      int unsigned                  w_sh;
      w_sh  = PRIO_MAX_W - width;
      w_tmp = raw << w_sh;
      if (is_signed) return w_tmp >>> w_sh;
      else           return w_tmp >> w_sh;
   endfunction

   // B wins only when valid and strictly more urgent; ties and double-invalid fall to A.
   function automatic sel_e node_sel(
      input node_t a,
      input node_t b,
      input logic  is_signed
   );
      logic w_a_gt_b;
      if (is_signed) w_a_gt_b = $signed(a.prio) > $signed(b.prio);
      else           w_a_gt_b = a.prio > b.prio;
      return (b.valid && (!a.valid || w_a_gt_b)) ? SEL_B : SEL_A;
   endfunction

endpackage

// File: rtl/edfic_arb_level.sv
// One tournament level: IN_N nodes reduced pairwise to IN_N/2 winners,
// optionally followed by a free-running register bank (no backpressure).
module edfic_arb_level
   import edfic_pkg::*;
#(
   parameter int IN_N        = 2,
   parameter bit PRIO_SIGNED = 1'b1,
   parameter bit REG_OUT     = 1'b0
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_flush,
   input  node_t [IN_N-1:0]    i_nodes,
   output node_t [IN_N/2-1:0]  o_nodes
);

   localparam int OUT_N = IN_N / 2;

   node_t [OUT_N-1:0] w_win;

   always_comb begin
      w_win = '0;
      for (int k = 0; k < OUT_N; k++) begin
         if (node_sel(i_nodes[2*k], i_nodes[2*k+1], PRIO_SIGNED) == SEL_B)
            w_win[k] = i_nodes[2*k+1];
         else
            w_win[k] = i_nodes[2*k];
      end
   end

   generate
      if (REG_OUT) begin : g_reg
         node_t [OUT_N-1:0] w_next;
         node_t [OUT_N-1:0] r_nodes;

         always_comb begin
            w_next = w_win;
            for (int k = 0; k < OUT_N; k++) begin
               w_next[k].valid = w_win[k].valid & ~i_flush;
            end
         end

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) r_nodes <= '0;
            else          r_nodes <= w_next;
         end

         assign o_nodes = r_nodes;
      end else begin : g_comb
         logic w_unused_ctl;
         assign w_unused_ctl = i_clk ^ i_rst_n ^ i_flush;
         assign o_nodes      = w_win;
      end
   endgenerate

endmodule

// File: rtl/edfic_arbiter_pipe.sv
// Pipelined deadline arbiter: binary tournament over NrInputs requests plus a valid/ready output register.
// Optional stall counter port stall_cnt_o is built when EDFIC_ARB_STALL_CNT_EN is defined.
module edfic_arbiter_pipe
   import edfic_pkg::*;
#(
   parameter int NrInputs   = 32,
   parameter int PrioWidth  = 8,
   parameter bit PrioSigned = 1'b1,
   parameter int RegEvery   = 2,
   localparam int IdxWidth  = (NrInputs > 2) ? $clog2(NrInputs) : 1,
   localparam int Levels    = $clog2(NrInputs),
   localparam int NrPad     = 1 << Levels,
   localparam int Latency   = (Levels + RegEvery - 1) / RegEvery
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          flush_i,
   input  logic [NrInputs-1:0]           valid_i,
   input  logic [NrInputs*PrioWidth-1:0] prio_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [PrioWidth-1:0]          out_prio_o,
   output logic [IdxWidth-1:0]           out_idx_o
`ifdef EDFIC_ARB_STALL_CNT_EN
   ,
   output logic [15:0]                   stall_cnt_o
`endif
);

   logic [NrPad-1:0]           w_valid_pad;
   logic [NrPad*PrioWidth-1:0] w_prio_pad;
   node_t [NrPad-1:0]          w_leaf;
   node_t                      w_tree;
   node_t                      r_out;
   logic                       w_load;
   logic                       w_unused_out;

   // Padding leaves are invalid, so they can never win against a real request.
   assign w_valid_pad = NrPad'(valid_i);
   assign w_prio_pad  = (NrPad*PrioWidth)'(prio_i);

   always_comb begin
      w_leaf = '0;
      for (int i = 0; i < NrPad; i++) begin
         w_leaf[i].valid = w_valid_pad[i];
         w_leaf[i].idx   = IDX_MAX_W'(i);
         w_leaf[i].prio  = prio_extend(PRIO_MAX_W'(w_prio_pad[i*PrioWidth +: PrioWidth]),
                                       PrioWidth, PrioSigned);
      end
   end

   generate
      for (genvar j = 0; j < Levels; j++) begin : g_lvl
         localparam int LVL_IN_N = NrPad >> j;
         localparam bit LVL_REG  = (((j + 1) % RegEvery) == 0) && (j < Levels - 1);

         node_t [LVL_IN_N-1:0]   w_in;
         node_t [LVL_IN_N/2-1:0] w_out;

         if (j == 0) begin : g_first
            assign w_in = w_leaf;
         end else begin : g_next
            assign w_in = g_lvl[j-1].w_out;
         end

         edfic_arb_level #(
            .IN_N        (LVL_IN_N),
            .PRIO_SIGNED (PrioSigned),
            .REG_OUT     (LVL_REG)
         ) u_level (
            .i_clk   (clk_i),
            .i_rst_n (rst_ni),
            .i_flush (flush_i),
            .i_nodes (w_in),
            .o_nodes (w_out)
         );
      end
   endgenerate

   assign w_tree = g_lvl[Levels-1].w_out[0];

   // Handshake: a transfer happens on out_valid_o && out_ready_i. The register
   // loads whenever it is empty or being consumed; otherwise the presented winner
   // stays frozen and tree results produced meanwhile are dropped (requests are
   // level-held upstream, so they are re-offered). flush_i overrides both.
   assign w_load = !r_out.valid || out_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)      r_out       <= '0;
      else if (flush_i) r_out.valid <= 1'b0;
      else if (w_load)  r_out       <= w_tree;
   end

   assign out_valid_o  = r_out.valid;
   assign out_prio_o   = r_out.prio[PrioWidth-1:0];
   assign out_idx_o    = r_out.idx[IdxWidth-1:0];
   assign w_unused_out = ^r_out;

`ifdef EDFIC_ARB_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         r_stall_cnt <= '0;
      else if (flush_i || (r_out.valid && out_ready_i))
         r_stall_cnt <= '0;
      else if (r_out.valid && !out_ready_i && (r_stall_cnt != 16'hFFFF))
         r_stall_cnt <= r_stall_cnt + 16'd1;
   end

   assign stall_cnt_o = r_stall_cnt;
`endif

`ifndef SYNTHESIS
   a_out_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (out_valid_o && !out_ready_i && !flush_i) |=>
      (out_valid_o && $stable(out_prio_o) && $stable(out_idx_o)));
`endif

endmodule
